pwm_timebase: RTL and testbench
===============================

# pwm_timebase

Parametrised PWM timebase for the RGB LED driver: a CE-qualified main counter with runtime-programmable top, software direction control, an automatic triangle (centre-aligned) mode, and per-channel duty comparators with period-synchronous duty shadowing. It sits between the prescaler (CE source) and debouncer (DIR source) and the LED output pins. It replaces the fixed 0..9 four-bit main/direction counter pair.

## Interface

- WIDTH, 4, bit width of MAIN_CNT, TOP and each duty field
- CHANNELS, 3, number of PWM channels (R, G, B by default)
- CLK  input  1  system clock, all state on rising edge
- CLR  input  1  asynchronous, active-low reset
- CE_IN  input  1  count enable from prescaler, one-cycle pulses
- DIR  input  1  direction-toggle request from debouncer, acted on only with CE_IN
- MODE  input  1  0 = sawtooth, 1 = triangle
- TOP  input  WIDTH  terminal count; counter range is 0..TOP
- DUTY  input  CHANNELS*WIDTH  duty per channel, channel i at [i*WIDTH +: WIDTH]
- DIR_CNT  output  1  current direction, 0 = increment, 1 = decrement
- MAIN_CNT  output  WIDTH  main counter
- PWM_OUT  output  CHANNELS  registered PWM outputs
- PERIOD_END  output  1  one-cycle pulse marking period start

## Operation

- Reset (CLR low, asynchronous, no clock needed): MAIN_CNT=0, DIR_CNT=0, all duty shadows=0, PWM_OUT=0, PERIOD_END=0.
- Priority per clock edge: (1) range fix, (2) CE step, (3) hold.
- Range fix: if MAIN_CNT > TOP, MAIN_CNT<=0 on the next edge regardless of CE_IN. DIR_CNT is unchanged, no PERIOD_END and no shadow load. This takes priority over a coincident CE step.
- Sawtooth (MODE=0), on CE_IN:
  - DIR_CNT=0: step MAIN_CNT+1. At TOP, wrap to 0 (boundary).
  - DIR_CNT=1: step MAIN_CNT-1. At 0, wrap to TOP (boundary).
  - DIR & CE_IN toggles DIR_CNT. The step on that same edge uses the pre-toggle direction.
- Triangle (MODE=1), on CE_IN:
  - DIR is ignored.
  - DIR_CNT=0 at TOP: DIR_CNT<=1, MAIN_CNT<=TOP-1.
  - DIR_CNT=1 at 0: DIR_CNT<=0, MAIN_CNT<=1 (boundary).
  - Otherwise step per DIR_CNT.
- TOP=0, either mode: MAIN_CNT holds 0, DIR_CNT holds, and every CE_IN is a boundary.
- MODE changes take effect on the next CE_IN and start from the current MAIN_CNT and DIR_CNT.
- Boundary edge:
  - Every duty shadow loads from DUTY.
  - PERIOD_END is 1 for exactly the following cycle, coincident with the new MAIN_CNT value.
- Compare: PWM_OUT[i] <= (MAIN_CNT < shadow[i]), unsigned, evaluated every clock and not gated by CE.
  - shadow=0 gives constant 0.
  - shadow >= TOP+1 gives constant 1.
- DUTY changes between boundaries have no effect on PWM_OUT.

## Timing

- MAIN_CNT and DIR_CNT update on the edge that samples CE_IN=1. They are visible the cycle after CE.
- PERIOD_END is registered and high in the same cycle the boundary value first appears on MAIN_CNT.
- PWM_OUT lags MAIN_CNT by one cycle. A new shadow affects PWM_OUT one cycle after PERIOD_END.
- Sawtooth period is TOP+1 CE pulses. Triangle period is 2*TOP CE pulses (TOP >= 1).
- A range-fix edge consumes no CE. A CE_IN arriving on the range-fix edge is lost.
- Back-to-back CE_IN (every cycle) is supported with no dead cycles.

## Test plan

- Reset, then MODE=0, TOP=9, CE_IN every cycle:
  - MAIN_CNT 0,1..9,0.
  - PERIOD_END high with each return to 0, every 10 CEs.
  - DIR_CNT stays 0.
- MODE=0, TOP=9, DIR pulse with CE_IN while MAIN_CNT=5:
  - MAIN_CNT goes to 6 and DIR_CNT goes to 1.
  - Then 5,4..0,9, with PERIOD_END on 9.
  - DIR+CE at MAIN_CNT=9 with DIR_CNT=0 gives 0, PERIOD_END, then DIR_CNT=1.
- MODE=1, TOP=9, from reset:
  - MAIN_CNT 0..9,8..0,1.
  - DIR_CNT 1 after 9 and 0 after 0.
  - PERIOD_END once per 18 CEs, with MAIN_CNT=1.
  - DIR pulses have no effect.
- MODE=0, TOP=9, DUTY={B=10,G=0,R=3}:
  - After the first PERIOD_END: PWM_OUT[0] high for counts 0..2 (3 of 10), PWM_OUT[1] always 0, PWM_OUT[2] always 1.
  - R set to 7 at count 4: no change until the next PERIOD_END, then 7 of 10.
- MAIN_CNT=8 with TOP changed 9->5 and no CE_IN:
  - MAIN_CNT=0 on the next edge.
  - No PERIOD_END, DIR_CNT unchanged, shadows unchanged.
- CLR driven low mid-count (MAIN_CNT=6, DIR_CNT=1, PWM_OUT=3'b101) between clock edges:
  - All outputs go to 0 immediately.
  - After release, counting restarts 0,1,...

Source files
------------

// File: rtl/pwm_timebase_if.sv
// Control and status bundle between the PWM timebase and its surroundings
// (prescaler CE, debouncer DIR, configuration registers, LED pins).
interface pwm_timebase_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3
);
  logic                      CE_IN;
  logic                      DIR;
  logic                      MODE;
  logic [WIDTH-1:0]          TOP;
  logic [CHANNELS*WIDTH-1:0] DUTY;
  logic                      DIR_CNT;
  logic [WIDTH-1:0]          MAIN_CNT;
  logic [CHANNELS-1:0]       PWM_OUT;
  logic                      PERIOD_END;

  modport master (
    output CE_IN, DIR, MODE, TOP, DUTY,
    input  DIR_CNT, MAIN_CNT, PWM_OUT, PERIOD_END
  );

  modport slave (
    input  CE_IN, DIR, MODE, TOP, DUTY,
    output DIR_CNT, MAIN_CNT, PWM_OUT, PERIOD_END
  );
endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: CE-qualified up/down main counter with sawtooth or triangle
// sweep, and per-channel duty comparators whose duty is shadowed per period.
module pwm_timebase #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3
) (
  input  logic CLK,
  input  logic CLR,
  pwm_timebase_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0]                main_q, main_d;
  logic                            dir_q, dir_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            pend_q, pend_d;
  logic                            boundary;

  // Range fix beats a CE step; a CE arriving on a range-fix edge is dropped.
  always_comb begin
    main_d   = main_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (main_q > bus.TOP) begin
      main_d = ZERO;
    end else if (bus.CE_IN) begin
      if (bus.TOP == ZERO) begin
        main_d   = ZERO;
        boundary = 1'b1;
      end else if (!bus.MODE) begin
        if (!dir_q) begin
          if (main_q == bus.TOP) begin
            main_d   = ZERO;
            boundary = 1'b1;
          end else begin
            main_d = main_q + ONE;
          end
        end else begin
          if (main_q == ZERO) begin
            main_d   = bus.TOP;
            boundary = 1'b1;
          end else begin
            main_d = main_q - ONE;
          end
        end
        if (bus.DIR) begin
          dir_d = ~dir_q;
        end
      end else begin
        // Triangle turns around at both ends; only the bottom turn ends a period.
        if (!dir_q) begin
          if (main_q == bus.TOP) begin
            dir_d  = 1'b1;
            main_d = bus.TOP - ONE;
          end else begin
            main_d = main_q + ONE;
          end
        end else begin
          if (main_q == ZERO) begin
            dir_d    = 1'b0;
            main_d   = ONE;
            boundary = 1'b1;
          end else begin
            main_d = main_q - ONE;
          end
        end
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    pend_d   = boundary;
    pwm_d    = '0;
    if (boundary) begin
      shadow_d = bus.DUTY;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (main_q < shadow_q[i]);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      main_q   <= '0;
      dir_q    <= 1'b0;
      shadow_q <= '0;
      pwm_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      main_q   <= main_d;
      dir_q    <= dir_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.MAIN_CNT   = main_q;
  assign bus.DIR_CNT    = dir_q;
  assign bus.PWM_OUT    = pwm_q;
  assign bus.PERIOD_END = pend_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: sawtooth, direction toggles, triangle,
// duty shadowing, range fix, TOP=0 and asynchronous reset.
module tb_pwm_timebase;

  logic clk;
  logic clr;
  int   checks;
  int   passes;

  pwm_timebase_if #(.WIDTH(4), .CHANNELS(3)) bus ();

  pwm_timebase #(.WIDTH(4), .CHANNELS(3)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so they are stable at the next one.
  task automatic applyStimulus(input logic ce, input logic dr);
    bus.CE_IN = ce;
    bus.DIR   = dr;
    @(posedge clk);
    #1;
    bus.CE_IN = 1'b0;
    bus.DIR   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic pulseReset();
    #2 clr = 1'b0;
    #2 clr = 1'b1;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    clk        = 1'b0;
    clr        = 1'b0;
    bus.CE_IN  = 1'b0;
    bus.DIR    = 1'b0;
    bus.MODE   = 1'b0;
    bus.TOP    = 4'd9;
    bus.DUTY   = '0;

    #12;
    checkOutput("rst_main", 32'(bus.MAIN_CNT), 32'd0);
    checkOutput("rst_dir",  32'(bus.DIR_CNT), 32'd0);
    checkOutput("rst_pwm",  32'(bus.PWM_OUT), 32'd0);
    checkOutput("rst_pend", 32'(bus.PERIOD_END), 32'd0);
    clr = 1'b1;

    // Sawtooth, TOP=9, CE every cycle
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("saw_main", 32'(bus.MAIN_CNT), 32'(k % 10));
      checkOutput("saw_pend", 32'(bus.PERIOD_END), 32'(k == 10));
      checkOutput("saw_dir",  32'(bus.DIR_CNT), 32'd0);
    end

    // Direction toggle at 5: step uses old direction, then counts down
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_tog_main", 32'(bus.MAIN_CNT), 32'd5);
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog_main", 32'(bus.MAIN_CNT), 32'd6);
    checkOutput("tog_dir",  32'(bus.DIR_CNT), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("down_main", 32'(bus.MAIN_CNT), 32'((k <= 6) ? (6 - k) : 9));
      checkOutput("down_pend", 32'(bus.PERIOD_END), 32'(k == 7));
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog2_main", 32'(bus.MAIN_CNT), 32'd8);
    checkOutput("tog2_dir",  32'(bus.DIR_CNT), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("up9_main", 32'(bus.MAIN_CNT), 32'd9);
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog_top_main", 32'(bus.MAIN_CNT), 32'd0);
    checkOutput("tog_top_pend", 32'(bus.PERIOD_END), 32'd1);
    checkOutput("tog_top_dir",  32'(bus.DIR_CNT), 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("tog_bot_main", 32'(bus.MAIN_CNT), 32'd9);
    checkOutput("tog_bot_dir",  32'(bus.DIR_CNT), 32'd0);

    // Triangle from reset, DIR pulses ignored
    bus.MODE = 1'b1;
    pulseReset();
    checkOutput("tri_rst_main", 32'(bus.MAIN_CNT), 32'd0);
    for (int k = 1; k <= 19; k++) begin
      applyStimulus(1'b1, 1'(k % 3 == 0));
      checkOutput("tri_main", 32'(bus.MAIN_CNT), 32'((k <= 9) ? k : ((k <= 18) ? (18 - k) : 1)));
      checkOutput("tri_dir",  32'(bus.DIR_CNT), 32'(k >= 10 && k <= 18));
      checkOutput("tri_pend", 32'(bus.PERIOD_END), 32'(k == 19));
    end

    // Duty shadowing: B=10, G=0, R=3, R->7 mid-period
    bus.MODE = 1'b0;
    bus.DUTY = {4'd10, 4'd0, 4'd3};
    pulseReset();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("pwm_pre", 32'(bus.PWM_OUT), 32'd0);
    end
    checkOutput("pwm_load_pend", 32'(bus.PERIOD_END), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("pwm_out", 32'(bus.PWM_OUT),
                  32'({1'b1, 1'b0, 1'(((k - 1) % 10) < ((k <= 10) ? 3 : 7))}));
      if (k == 4) bus.DUTY = {4'd10, 4'd0, 4'd7};
    end

    // Range fix: TOP lowered below MAIN_CNT, with and without CE
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("rf_pre_main", 32'(bus.MAIN_CNT), 32'd8);
    bus.TOP = 4'd5;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rf_main", 32'(bus.MAIN_CNT), 32'd0);
    checkOutput("rf_pend", 32'(bus.PERIOD_END), 32'd0);
    checkOutput("rf_dir",  32'(bus.DIR_CNT), 32'd0);
    checkOutput("rf_pwm8", 32'(bus.PWM_OUT), 32'b100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rf_pwm0", 32'(bus.PWM_OUT), 32'b101);
    bus.TOP = 4'd9;
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 1'b0);
    bus.TOP = 4'd5;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rf_ce_main", 32'(bus.MAIN_CNT), 32'd0);
    checkOutput("rf_ce_pend", 32'(bus.PERIOD_END), 32'd0);

    // TOP=0: counter holds and every CE is a boundary
    bus.TOP = 4'd0;
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("top0_main", 32'(bus.MAIN_CNT), 32'd0);
      checkOutput("top0_pend", 32'(bus.PERIOD_END), 32'd1);
      checkOutput("top0_dir",  32'(bus.DIR_CNT), 32'd0);
    end
    bus.TOP = 4'd9;

    // Asynchronous clear in mid-count, between edges
    pulseReset();
    for (int k = 1; k <= 15; k++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("clr_pre_main", 32'(bus.MAIN_CNT), 32'd6);
    checkOutput("clr_pre_dir",  32'(bus.DIR_CNT), 32'd1);
    checkOutput("clr_pre_pwm",  32'(bus.PWM_OUT), 32'b101);
    #2 clr = 1'b0;
    #1;
    checkOutput("clr_main", 32'(bus.MAIN_CNT), 32'd0);
    checkOutput("clr_dir",  32'(bus.DIR_CNT), 32'd0);
    checkOutput("clr_pwm",  32'(bus.PWM_OUT), 32'd0);
    checkOutput("clr_pend", 32'(bus.PERIOD_END), 32'd0);
    #2 clr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("post_clr_main", 32'(bus.MAIN_CNT), 32'(k));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
